// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out front end for an MSB-bit shift register. A word is
// taken over a valid/ready handshake, then sent one bit per DIV clock cycles.
// Each bit comes with a one-cycle strobe and a direction flag. An optional gap
// of GAP bit-times holds the serial line at 0 between words.
//
// Ports
//   clk_i    : clock; all logic changes on the rising edge
//   rst_i    : synchronous reset, active-high; takes priority over everything
//   word_i   : parallel word, sampled only when it is accepted
//   valid_i  : word_i/dir_i are valid; must be held until accepted
//   dir_i    : 0 = word_i[MSB-1] goes first, 1 = word_i[0] goes first
//   ready_o  : high only in IDLE; a transfer happens on valid_i && ready_o
//   data_o   : current serial bit (drives the shift register's data_i)
//   en_o     : one-cycle strobe per bit (drives the shift register's en_i)
//   dir_o    : direction latched for the current word (drives dir_i)
//   busy_o   : high while a word is shifting or in the inter-word gap
//   done_o   : one-cycle pulse in the cycle after the last bit's strobe
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int MSB = 8,  // word width, >= 2
  parameter int DIV = 4,  // clock cycles per serial bit, >= 1
  parameter int GAP = 1   // idle bit-times between words, >= 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [MSB-1:0] word_i,
  input  logic           valid_i,
  input  logic           dir_i,
  output logic           ready_o,
  output logic           data_o,
  output logic           en_o,
  output logic           dir_o,
  output logic           busy_o,
  output logic           done_o
);

  // Counter widths. Each counter keeps at least one bit, so the degenerate
  // DIV=1 and GAP=0 settings still produce legal vectors.
  localparam int BIT_W = $clog2(MSB);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W = (GAP * DIV > 0) ? $clog2(GAP * DIV + 1) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(MSB - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP * DIV - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q,   state_d;
  logic [MSB-1:0]   shadow_q,  shadow_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             dir_q,     dir_d;
  logic             done_q,    done_d;

  logic [BIT_W-1:0] bit_idx;
  logic             strobe;

  // The strobe is decoded from registered state only. data_o therefore stays
  // stable for the whole cycle in which the downstream register samples it.
  assign strobe  = (state_q == S_SHIFT) && (div_cnt_q == DIV_LAST);

  // Bit k of the word goes out k-th in LSB-first order, and as bit MSB-1-k in
  // MSB-first order.
  assign bit_idx = dir_q ? bit_cnt_q : (BIT_LAST - bit_cnt_q);

  // Next-state logic
  // NOTE: every signal written in this block gets a default first. Then no path
  // through the case leaves a signal unassigned, and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    gap_cnt_d = gap_cnt_q;
    dir_d     = dir_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          shadow_d  = word_i;
          dir_d     = dir_i;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            // The last bit is being strobed now; the pulse lands in the
            // following cycle.
            done_d    = 1'b1;
            bit_cnt_d = '0;
            if (GAP > 0) begin
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end else begin
              state_d   = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      // NOTE: the shadow word is a plain register, not a memory array. It is
      // cleared like everything else, so a word aborted by reset leaves
      // nothing behind.
      shadow_q  <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
    end
  end

  // Outputs
  assign ready_o = (state_q == S_IDLE);
  assign busy_o  = (state_q == S_SHIFT) || (state_q == S_GAP);
  assign data_o  = (state_q == S_SHIFT) ? shadow_q[bit_idx] : 1'b0;
  assign en_o    = strobe;
  assign dir_o   = dir_q;
  assign done_o  = done_q;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out front end that sits directly upstream of the N-bit shift register.
- Accepts an MSB-bit word over a valid/ready handshake.
- Emits the word one bit at a time on data_o, with a per-bit strobe en_o and a direction flag dir_o. These drive the shift register's data_i, en_i and dir_i.
- Bit rate is clk_i/DIV. An optional inter-word gap keeps the serial line at 0 between words.

Parameters:
- MSB, 8, word width in bits; must match the downstream shift register (>= 2).
- DIV, 4, clk_i cycles per serial bit (>= 1).
- GAP, 1, idle bit-times between words (>= 0).

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- word_i  input  MSB  parallel word to send.
- valid_i  input  1  word_i/dir_i valid; must be held until accepted.
- dir_i  input  1  bit order: 0 = word_i[MSB-1] first, 1 = word_i[0] first.
- ready_o  output  1  high only in IDLE; transfer when valid_i && ready_o at a rising edge.
- data_o  output  1  current serial bit; drives shift register data_i.
- en_o  output  1  one-cycle strobe per bit; drives shift register en_i.
- dir_o  output  1  latched dir_i for the current word; drives shift register dir_i.
- busy_o  output  1  high in SHIFT or GAP.
- done_o  output  1  one-cycle pulse after the last bit's strobe.

Behaviour:
- Reset (rst_i high at an edge):
  - State goes to IDLE.
  - Outputs: ready_o=1, data_o=0, en_o=0, dir_o=0, busy_o=0, done_o=0.
  - Shadow register and counters are cleared.
  - Reset mid-word aborts the word: no further en_o, no done_o. Reset has priority over every other event.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - ready_o=1, data_o=0, en_o=0.
  - On valid_i at an edge (E0): latch word_i into the shadow register, latch dir_i into dir_o, clear bit_cnt and div_cnt, enter SHIFT.
- SHIFT:
  - data_o = shadow[MSB-1-bit_cnt] if dir_o=0, else shadow[bit_cnt].
  - Each bit is held for DIV cycles; div_cnt counts 0..DIV-1.
  - en_o = (state==SHIFT && div_cnt==DIV-1), decoded from registers, so data_o is stable for the whole strobe cycle.
  - The downstream register samples bit k at edge E0+(k+1)*DIV.
  - When div_cnt wraps: bit_cnt increments.
  - After the strobe of bit MSB-1 (edge E0+MSB*DIV): enter GAP if GAP>0, else IDLE. done_o is high for exactly the following cycle.
- GAP:
  - Lasts GAP*DIV cycles; data_o=0, en_o=0, ready_o=0.
  - Then enters IDLE; ready_o is high from edge E0+(MSB+GAP)*DIV.
- Timing:
  - Latency: first bit on data_o the cycle after E0; first strobe DIV cycles after E0.
  - Throughput with valid_i held: one word per (MSB+GAP)*DIV+1 cycles. The +1 is the IDLE accept cycle.
- DIV=1: en_o is high every SHIFT cycle.
- GAP=0: done_o and ready_o are both high in the IDLE cycle, so a new word may be accepted there.
- Input handling:
  - word_i and dir_i are sampled only at accept; later changes are ignored until the next accept.
  - valid_i while busy is ignored and not queued.
  - dir_o keeps its last value in IDLE and GAP.
- Counter widths: bit_cnt = clog2(MSB), div_cnt = clog2(DIV) (min 1 bit), gap counter = clog2(GAP*DIV+1).

Test Plan:
- Reset: rst_i high 2 cycles mid-stream → next cycle ready_o=1, data_o=0, en_o=0, busy_o=0, done_o=0, dir_o=0.
- MSB=8, DIV=4, GAP=1; word_i=8'hA5, dir_i=0, accepted at edge 0:
  - data_o = 1,0,1,0,0,1,0,1, each held 4 cycles.
  - en_o high in cycles 3,7,...,31 (8 strobes).
  - done_o high one cycle after edge 32; ready_o high after edge 36.
  - Downstream shift register reads 8'hA5.
- word_i=8'h01, dir_i=1 → data_o = 1 then seven 0s; dir_o=1 for the whole word.
- Hold-off:
  - During 8'hA5, valid_i=1 with word_i=8'h3C; toggle dir_i every cycle.
  - → ready_o stays 0; the 8'hA5 bit stream is unchanged.
  - 8'h3C is accepted at the first edge with ready_o=1, using the dir_i value at that edge.
- rst_i pulsed for 1 cycle during bit 3 → next cycle all outputs at reset values, no done_o. A following word 8'hF0 serializes completely and correctly.
- DIV=1, GAP=0; 8'hFF then 8'h00 with valid_i held:
  - en_o high 8 consecutive cycles, data_o=1 throughout.
  - One IDLE cycle with done_o=1 and ready_o=1, then 8 strobes with data_o=0.
